pia_multi: RTL and testbench
============================

# pia_multi

Parametrised successor to the two-port MC6820 peripheral interface adapter. It provides NPORTS independent channels of WIDTH bits. Each channel has an output register, a data-direction register, a control register, C1/C2 edge-detected interrupt lines and a C2 handshake/strobe output. It sits on the CPU bus next to the existing PIA, using the same chip-select and register-select style, with an added per-channel active-low interrupt vector.

## Interface
- NPORTS, 2: number of channels, 1..8.
- WIDTH, 8: port width and CPU data bus width, 4..16.
- RSW, $clog2(NPORTS)+1: register-select width. RS[0] selects data/DDR versus control; RS[RSW-1:1] selects the channel.
- enable  in  1  bus E clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- DI  in  WIDTH  CPU write data.
- DO  out  WIDTH  CPU read data.
- CS  in  3  chip select; the block is selected only when CS == 3'b011.
- RS  in  RSW  register select.
- rw  in  1  1 = read, 0 = write.
- PI  in  NPORTS*WIDTH  port input pins; channel i occupies bits [i*WIDTH +: WIDTH].
- PO  out  NPORTS*WIDTH  output register contents.
- PDIR  out  NPORTS*WIDTH  DDR contents; 1 = pin driven from PO.
- C1  in  NPORTS  per-channel interrupt/strobe input.
- C2I  in  NPORTS  C2 input, used when C2 is configured as an input.
- C2O  out  NPORTS  C2 output.
- irq  out  NPORTS  per-channel interrupt, active low.

## Operation
- Control register CR[i] is 8 bits; only the low 8 bits of the bus are used for it.
  - bit0: C1 IRQ enable.
  - bit1: C1 active edge; 1 = rising, 0 = falling.
  - bit2: 1 = data register at RS[0]=0, 0 = DDR at RS[0]=0.
  - bits5:3: C2 mode.
  - bit6: IRQ2 flag, read-only.
  - bit7: IRQ1 flag, read-only.
- C2 modes:
  - bit5=0: C2 is an input. bit3 = IRQ2 enable, bit4 = active edge (1 = rising).
  - 1,1,x: manual mode. C2O = bit3.
  - 1,0,0: handshake. C2O goes low on a data-register read and returns high on the next C1 active edge.
  - 1,0,1: pulse. C2O is low for exactly one enable cycle after a data-register read.
- Data register read returns (PI & ~DDR) | (OR & DDR). A DDR read returns the DDR.
- A data-register read clears both IRQ flags of that channel.
- Writes go to OR, DDR or CR[5:0]. Writes never modify CR[7:6].
- An out-of-range channel (index ≥ NPORTS) reads as 0, and writes to it are ignored.
- Edge detection:
  - Each C1/C2I is sampled into a previous-value flop every cycle.
  - An active edge is current != previous, in the polarity selected by CR.
  - Flags set regardless of their enable bits.
  - C2 flag detection is disabled while bit5=1.
- irq[i] = ~((CR7 & CR0) | (CR6 & CR3 & ~CR5)).
- DO is combinational from the addressed register when selected and rw=1; otherwise DO = 0.

## Timing
- All register writes, flag updates and C2O changes take effect at the enable rising edge where the access or edge is sampled.
- Reset values (immediate on reset_n low, independent of clock): OR, DDR and CR all 0; PO = 0; PDIR = 0; C2O all 1; irq all 1; edge history flops = 0.
- Edge-to-flag latency: a pin transition sampled at edge k sets the flag at edge k; irq falls after edge k.
- Flag clear: a read at edge k clears the flags at edge k. DO during that cycle still shows the pre-clear value.
- Simultaneous flag set and clear in the same cycle: set wins, and the flag remains 1.
- Handshake: a read and a C1 active edge in the same cycle leave C2O high.
- Pulse mode:
  - C2O is low for the cycle following the read edge.
  - It is high again at the next edge.
  - Back-to-back reads hold it low continuously.
- A CR write that changes an edge polarity does not generate a spurious flag; the history flop is unaffected.
- Reset mid-handshake: C2O returns to 1 and any pending flag is cleared.

## Configuration
- PIA_C2_PULSE_EN
  - Defined: C2 mode 1,0,1 is the one-cycle pulse described above.
  - Undefined: mode 1,0,1 behaves exactly as handshake mode 1,0,0, and the pulse logic is not synthesised.

## Test plan
- Reset with NPORTS=2, WIDTH=8 -> all reads return 0; C2O = 2'b11; irq = 2'b11; PO = 0.
- Write DDR0 = 8'hF0, write CR0 = 8'h04, write OR0 = 8'hA5, with PI[7:0] = 8'h3C -> data0 reads 8'hAC; PO[7:0] = 8'hA5.
- CR1 = 8'h07 (rising edge, IRQ enabled), C1[1] rises -> irq[1] = 0 at that edge; CR1 reads 8'h87; a data1 read returns irq[1] to 1.
- CR0 = 8'h24 (handshake): read data0 -> C2O[0] = 0; C1[0] falling edge with CR0 bit1 = 0 -> C2O[0] = 1 at that edge.
- With PIA_C2_PULSE_EN, CR0 = 8'h2C: read data0 -> C2O[0] is low for exactly one cycle. Without the macro, it stays low until a C1 edge.
- C1 edge in the same cycle as a clearing read -> CR7 remains 1 and irq stays 0.

Source files
------------

// File: rtl/pia_multi.sv
// Multi-channel peripheral interface adapter: NPORTS channels of OR/DDR/CR with C1/C2 edge flags and C2 handshake.
// Optional feature macro PIA_C2_PULSE_EN enables the one-cycle C2 pulse mode (CR[5:3] = 3'b101).
module pia_multi #(
    parameter int NPORTS = 2,
    parameter int WIDTH  = 8,
    parameter int RSW    = $clog2(NPORTS) + 1
) (
    input  logic                     enable,
    input  logic                     reset_n,
    input  logic [WIDTH-1:0]         DI,
    output logic [WIDTH-1:0]         DO,
    input  logic [2:0]               CS,
    input  logic [RSW-1:0]           RS,
    input  logic                     rw,
    input  logic [NPORTS*WIDTH-1:0]  PI,
    output logic [NPORTS*WIDTH-1:0]  PO,
    output logic [NPORTS*WIDTH-1:0]  PDIR,
    input  logic [NPORTS-1:0]        C1,
    input  logic [NPORTS-1:0]        C2I,
    output logic [NPORTS-1:0]        C2O,
    output logic [NPORTS-1:0]        irq
);

    logic             sel;
    logic [RSW-1:0]   chan;
    logic [5:0]       cr_wdata;
    logic [WIDTH-1:0] ch_do [NPORTS];
    logic [WIDTH-1:0] do_or;

    assign sel      = (CS == 3'b011);
    assign chan     = RS >> 1;
    assign cr_wdata = 6'(DI);

    genvar gi;
    generate
        for (gi = 0; gi < NPORTS; gi++) begin : g_chan
            logic [WIDTH-1:0] or_reg;
            logic [WIDTH-1:0] ddr_reg;
            logic [5:0]       cr_reg;
            logic             flag1_reg;
            logic             flag2_reg;
            logic             c1_prev_reg;
            logic             c2_prev_reg;
            logic             hs_reg;
            logic             hit;
            logic             data_acc;
            logic             ddr_acc;
            logic             cr_acc;
            logic             data_rd;
            logic             c1_edge;
            logic             c2_edge;
            logic             hs_mode;
            logic             c2o_bit;
            logic [WIDTH-1:0] pin_val;
            logic [WIDTH-1:0] port_val;
            logic [7:0]       cr_full;

            assign hit      = sel && (chan == RSW'(gi));
            assign data_acc = hit && !RS[0] && cr_reg[2];
            assign ddr_acc  = hit && !RS[0] && !cr_reg[2];
            assign cr_acc   = hit && RS[0];
            assign data_rd  = data_acc && rw;

            assign pin_val  = PI[gi*WIDTH +: WIDTH];
            assign port_val = (pin_val & ~ddr_reg) | (or_reg & ddr_reg);
            assign cr_full  = {flag1_reg, flag2_reg, cr_reg};

            assign ch_do[gi] = data_acc ? port_val :
                               ddr_acc  ? ddr_reg  :
                               cr_acc   ? WIDTH'(cr_full) : '0;

            // Edge polarity comes from CR; the history flops are independent of it.
            assign c1_edge = cr_reg[1] ? (C1[gi] & ~c1_prev_reg) : (~C1[gi] & c1_prev_reg);
            assign c2_edge = ~cr_reg[5] &
                             (cr_reg[4] ? (C2I[gi] & ~c2_prev_reg) : (~C2I[gi] & c2_prev_reg));

`ifdef PIA_C2_PULSE_EN
            logic pulse_mode;
            logic pulse_reg;

            assign hs_mode    = (cr_reg[5:3] == 3'b100);
            assign pulse_mode = (cr_reg[5:3] == 3'b101);

            always_ff @(posedge enable or negedge reset_n) begin
                if (!reset_n) begin
                    pulse_reg <= 1'b1;
                end else begin
                    pulse_reg <= ~(data_rd & pulse_mode);
                end
            end
`else
            assign hs_mode = (cr_reg[5:4] == 2'b10);
`endif

            always_comb begin
                c2o_bit = 1'b1;
                if (cr_reg[5] && cr_reg[4]) begin
                    c2o_bit = cr_reg[3];
                end else if (hs_mode) begin
                    c2o_bit = hs_reg;
`ifdef PIA_C2_PULSE_EN
                end else if (pulse_mode) begin
                    c2o_bit = pulse_reg;
`endif
                end
            end

            always_ff @(posedge enable or negedge reset_n) begin
                if (!reset_n) begin
                    or_reg      <= '0;
                    ddr_reg     <= '0;
                    cr_reg      <= '0;
                    flag1_reg   <= 1'b0;
                    flag2_reg   <= 1'b0;
                    c1_prev_reg <= 1'b0;
                    c2_prev_reg <= 1'b0;
                    hs_reg      <= 1'b1;
                end else begin
                    c1_prev_reg <= C1[gi];
                    c2_prev_reg <= C2I[gi];
                    if (data_acc && !rw) or_reg   <= DI;
                    if (ddr_acc && !rw)  ddr_reg  <= DI;
                    if (cr_acc && !rw)   cr_reg   <= cr_wdata;
                    // A new edge wins over a clearing read in the same cycle.
                    flag1_reg <= c1_edge | (flag1_reg & ~data_rd);
                    flag2_reg <= c2_edge | (flag2_reg & ~data_rd);
                    if (c1_edge || !hs_mode) begin
                        hs_reg <= 1'b1;
                    end else if (data_rd) begin
                        hs_reg <= 1'b0;
                    end
                end
            end

            assign PO[gi*WIDTH +: WIDTH]   = or_reg;
            assign PDIR[gi*WIDTH +: WIDTH] = ddr_reg;
            assign C2O[gi] = c2o_bit;
            assign irq[gi] = ~((flag1_reg & cr_reg[0]) | (flag2_reg & cr_reg[3] & ~cr_reg[5]));
        end
    endgenerate

    always_comb begin
        do_or = '0;
        for (int i = 0; i < NPORTS; i++) begin
            do_or = do_or | ch_do[i];
        end
    end

    assign DO = (sel && rw) ? do_or : '0;

endmodule

// File: tb/tb_pia_multi.sv
// Directed scoreboard bench for pia_multi (NPORTS=2, WIDTH=8); honours PIA_C2_PULSE_EN when defined.
module tb_pia_multi;
    localparam int NPORTS = 2;
    localparam int WIDTH  = 8;
    localparam int RSW    = 2;

    logic                    enable = 1'b0;
    logic                    reset_n = 1'b1;
    logic [WIDTH-1:0]        DI = '0;
    logic [WIDTH-1:0]        DO;
    logic [2:0]              CS = 3'b000;
    logic [RSW-1:0]          RS = '0;
    logic                    rw = 1'b1;
    logic [NPORTS*WIDTH-1:0] PI = '0;
    logic [NPORTS*WIDTH-1:0] PO;
    logic [NPORTS*WIDTH-1:0] PDIR;
    logic [NPORTS-1:0]       C1 = '0;
    logic [NPORTS-1:0]       C2I = '0;
    logic [NPORTS-1:0]       C2O;
    logic [NPORTS-1:0]       irq;

    int tests = 0;
    int fails = 0;
    logic [WIDTH-1:0] exp_q [$];

`ifdef PIA_C2_PULSE_EN
    localparam logic PULSE_ON = 1'b1;
`else
    localparam logic PULSE_ON = 1'b0;
`endif

    pia_multi #(.NPORTS(NPORTS), .WIDTH(WIDTH), .RSW(RSW)) dut (
        .enable (enable),
        .reset_n(reset_n),
        .DI     (DI),
        .DO     (DO),
        .CS     (CS),
        .RS     (RS),
        .rw     (rw),
        .PI     (PI),
        .PO     (PO),
        .PDIR   (PDIR),
        .C1     (C1),
        .C2I    (C2I),
        .C2O    (C2O),
        .irq    (irq)
    );

    always #5 enable = ~enable;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge enable);
    endtask

    task automatic wr(input logic [2:0] cs, input logic [RSW-1:0] a, input logic [7:0] d);
        CS = cs; RS = a; rw = 1'b0; DI = d;
        @(negedge enable);
        CS = 3'b000; rw = 1'b1;
        $display("[TB] write cs=%b rs=%0d data=%h", cs, a, d);
    endtask

    task automatic rd(input logic [2:0] cs, input logic [RSW-1:0] a,
                      input logic [7:0] exp, input string tag);
        logic [WIDTH-1:0] obs;
        exp_q.push_back(exp);
        CS = cs; RS = a; rw = 1'b1;
        #1 obs = DO;
        @(negedge enable);
        CS = 3'b000;
        $display("[TB] read  cs=%b rs=%0d data=%h", cs, a, obs);
        chk(tag, obs, exp_q.pop_front());
    endtask

    initial begin
        #1 reset_n = 1'b0;
        #1;
        chk("reset PO", PO, 0);
        chk("reset PDIR", PDIR, 0);
        chk("reset C2O", C2O, 2'b11);
        chk("reset irq", irq, 2'b11);
        tick();
        reset_n = 1'b1;
        rd(3'b011, 0, 8'h00, "reset ddr0");
        rd(3'b011, 1, 8'h00, "reset cr0");
        rd(3'b011, 2, 8'h00, "reset ddr1");
        rd(3'b011, 3, 8'h00, "reset cr1");

        // Port mixing of pins and output register under DDR
        wr(3'b011, 0, 8'hF0);
        wr(3'b011, 1, 8'h04);
        wr(3'b011, 0, 8'hA5);
        PI[7:0] = 8'h3C;
        rd(3'b011, 0, 8'hAC, "data0 mix");
        chk("PO0", PO[7:0], 8'hA5);
        chk("PDIR0", PDIR[7:0], 8'hF0);
        rd(3'b011, 1, 8'h04, "cr0 readback");
        C1[0] = 1'b1;   // rising edge, inactive for falling polarity
        tick();
        chk("cr0 no flag on inactive edge", irq[0], 1'b1);

        // C1 rising-edge interrupt on channel 1
        PI[15:8] = 8'h5A;
        wr(3'b011, 3, 8'h07);
        C1[1] = 1'b1;
        tick();
        chk("irq1 asserted", irq[1], 1'b0);
        chk("irq0 idle", irq[0], 1'b1);
        rd(3'b011, 3, 8'h87, "cr1 flag1");
        rd(3'b011, 2, 8'h5A, "data1 read");
        chk("irq1 cleared", irq[1], 1'b1);

        // Handshake mode
        wr(3'b011, 1, 8'h24);
        chk("hs C2O idle", C2O[0], 1'b1);
        rd(3'b011, 0, 8'hAC, "hs data0");
        chk("hs C2O low", C2O[0], 1'b0);
        tick();
        chk("hs C2O held", C2O[0], 1'b0);
        C1[0] = 1'b0;
        tick();
        chk("hs C2O released", C2O[0], 1'b1);
        chk("hs irq0 masked", irq[0], 1'b1);
        rd(3'b011, 1, 8'hA4, "cr0 flag1 after hs");

        // Pulse mode (or handshake when the pulse feature is absent)
        wr(3'b011, 1, 8'h2C);
        chk("pulse C2O idle", C2O[0], 1'b1);
        rd(3'b011, 0, 8'hAC, "pulse data0");
        chk("pulse C2O low", C2O[0], 1'b0);
        tick();
        chk("pulse C2O after one cycle", C2O[0], PULSE_ON);
        rd(3'b011, 0, 8'hAC, "pulse b2b read1");
        chk("pulse b2b low1", C2O[0], 1'b0);
        rd(3'b011, 0, 8'hAC, "pulse b2b read2");
        chk("pulse b2b low2", C2O[0], 1'b0);
        tick();
        chk("pulse b2b end", C2O[0], PULSE_ON);
        rd(3'b011, 1, 8'h2C, "cr0 flags cleared");

        // Flag set and clearing read in the same cycle
        C1[1] = 1'b0;
        tick();
        rd(3'b011, 3, 8'h07, "cr1 no flag on fall");
        C1[1] = 1'b1;
        rd(3'b011, 2, 8'h5A, "data1 with edge");
        chk("set wins irq1", irq[1], 1'b0);
        rd(3'b011, 3, 8'h87, "set wins cr1");
        rd(3'b011, 2, 8'h5A, "data1 clear");
        chk("irq1 clear again", irq[1], 1'b1);

        // Polarity change must not create a flag
        wr(3'b011, 3, 8'h05);
        tick();
        rd(3'b011, 3, 8'h05, "cr1 polarity no flag");
        chk("irq1 polarity", irq[1], 1'b1);

        // Deselected accesses
        wr(3'b111, 0, 8'h00);
        chk("bad cs write", PO[7:0], 8'hA5);
        rd(3'b001, 0, 8'h00, "bad cs read");

        // Reset in the middle of a handshake
        wr(3'b011, 1, 8'h24);
        rd(3'b011, 0, 8'hAC, "hs before reset");
        chk("hs low before reset", C2O[0], 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid reset C2O", C2O, 2'b11);
        chk("mid reset irq", irq, 2'b11);
        chk("mid reset PO", PO, 0);
        chk("mid reset PDIR", PDIR, 0);
        tick();
        reset_n = 1'b1;
        rd(3'b011, 1, 8'h00, "cr0 after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
